uart_rx_unit: RTL and testbench

UART_RX_UNIT -- requirements
Module: uart_rx_unit

---
 rtl/uart_rx_unit_if.sv | 28 ++
 rtl/uart_rx_unit.sv | 179 +++++++++++++++++
 tb/tb_uart_rx_unit.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_unit_if.sv
// Receive-side bundle for uart_rx_unit: serial line in, byte FIFO read port,
// status flags and the FSM state for observation.
interface uart_rx_unit_if;
  logic       uart_input_line;
  logic       uart_fifo_read_en;
  logic [7:0] uart_fifo_data;
  logic       fifo_empty;
  logic       fifo_out_valid;
  logic       frame_error;
  logic       overrun;
  logic       parity_error;
  logic [2:0] rx_state;

  // Read handshake: uart_fifo_read_en while !fifo_empty pops the head byte;
  // that byte appears on uart_fifo_data with fifo_out_valid high for exactly
  // the next cycle. A request while fifo_empty is ignored (no valid pulse).
  modport slave (
    input  uart_input_line, uart_fifo_read_en,
    output uart_fifo_data, fifo_empty, fifo_out_valid,
    output frame_error, overrun, parity_error, rx_state
  );

  modport master (
    output uart_input_line, uart_fifo_read_en,
    input  uart_fifo_data, fifo_empty, fifo_out_valid,
    input  frame_error, overrun, parity_error, rx_state
  );
endinterface

// File: rtl/uart_rx_unit.sv
// UART receiver (8 data bits, LSB first) feeding a DEPTH-entry byte FIFO.
// Define UART_RX_PARITY_EN to expect an even parity bit before the stop bit.
module uart_rx_unit #(
  parameter int DEPTH      = 32,
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115200
) (
  input logic         clk,
  input logic         rst,
  uart_rx_unit_if.slave bus
);
  localparam int BAUD_TICKS = CLOCK_FREQ / BAUD_RATE;
  localparam int CNT_W      = $clog2(BAUD_TICKS + 1);
  localparam int AW         = $clog2(DEPTH);

  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(BAUD_TICKS / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(BAUD_TICKS - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;
  localparam logic [2:0] BREAK  = 3'd5;

  logic             sync1, sync2, sync_prev;
  logic [2:0]       state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             tick;
  logic             par_ok;
  logic             push;

  assign tick = (baud_cnt == FULL_M1);

`ifdef UART_RX_PARITY_EN
  logic par_bad;
  assign par_ok = !par_bad;
`else
  assign par_ok = 1'b1;
`endif

  // A byte is accepted on the stop-bit sample; errors are registered pulses.
  assign push = (state == STOP) && tick && sync2 && par_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1           <= 1'b1;
      sync2           <= 1'b1;
      sync_prev       <= 1'b1;
      state           <= IDLE;
      baud_cnt        <= '0;
      bit_idx         <= '0;
      shift           <= '0;
      bus.frame_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad          <= 1'b0;
      bus.parity_error <= 1'b0;
`endif
    end else begin
      sync1           <= bus.uart_input_line;
      sync2           <= sync1;
      sync_prev       <= sync2;
      bus.frame_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
      bus.parity_error <= 1'b0;
`endif
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          bit_idx  <= '0;
          if (sync_prev && !sync2) state <= START;
        end
        START: begin
          if (baud_cnt == HALF_M1) begin
            baud_cnt <= '0;
            state    <= sync2 ? IDLE : DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (tick) begin
            baud_cnt <= '0;
            shift    <= {sync2, shift[7:1]};
            bit_idx  <= bit_idx + 1'b1;
`ifdef UART_RX_PARITY_EN
            if (bit_idx == 3'd7) state <= PARITY;
`else
            if (bit_idx == 3'd7) state <= STOP;
`endif
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        PARITY: begin
`ifdef UART_RX_PARITY_EN
          if (tick) begin
            baud_cnt <= '0;
            par_bad  <= (sync2 != ^shift);
            state    <= STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
`else
          state <= IDLE;
`endif
        end
        STOP: begin
          if (tick) begin
            baud_cnt <= '0;
            if (!sync2) begin
              bus.frame_error <= 1'b1;
              state           <= BREAK;
            end else begin
`ifdef UART_RX_PARITY_EN
              bus.parity_error <= par_bad;
`endif
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        BREAK: begin
          // Held-low line must return high before another start is seen.
          if (sync2) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef UART_RX_PARITY_EN
  assign bus.parity_error = 1'b0;
`endif

  logic [7:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, pop, push_ok;

  // Occupancy never exceeds DEPTH, so its MSB alone marks full.
  assign full    = count[AW];
  assign pop     = bus.uart_fifo_read_en && (count != '0);
  assign push_ok = push && !full;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= shift;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      count              <= '0;
      bus.uart_fifo_data <= 8'h00;
      bus.fifo_out_valid <= 1'b0;
      bus.overrun        <= 1'b0;
    end else begin
      bus.fifo_out_valid <= pop;
      if (pop) begin
        bus.uart_fifo_data <= mem[rd_ptr];
        rd_ptr             <= rd_ptr + 1'b1;
      end
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (push && full) bus.overrun <= 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign bus.fifo_empty = (count == '0);
  assign bus.rx_state   = state;
endmodule

// File: tb/tb_uart_rx_unit.sv
// Directed bench for uart_rx_unit: one instance at default baud timing and a
// fast-baud instance for filling the FIFO.
module tb_uart_rx_unit;
  localparam int T0 = 434;
  localparam int T1 = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_rx_unit_if u0_if ();
  uart_rx_unit_if u1_if ();

  uart_rx_unit #(.DEPTH(32)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (u0_if.slave)
  );

  uart_rx_unit #(.DEPTH(32), .CLOCK_FREQ(1_600_000), .BAUD_RATE(100_000)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (u1_if.slave)
  );

  int tests = 0;
  int fails = 0;
  int fe0 = 0, pe0 = 0, fe1 = 0, pe1 = 0;
  logic [7:0] exp_q[$];

  always @(negedge clk) begin
    if (u0_if.frame_error === 1'b1) fe0++;
    if (u0_if.parity_error === 1'b1) pe0++;
    if (u1_if.frame_error === 1'b1) fe1++;
    if (u1_if.parity_error === 1'b1) pe1++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input int sel, input logic v, input int t);
    if (sel == 0) u0_if.uart_input_line = v;
    else          u1_if.uart_input_line = v;
    repeat (t) @(negedge clk);
  endtask

  task automatic send(input int sel, input logic [7:0] b, input logic stop_b, input logic par_b);
    int t;
    t = (sel == 0) ? T0 : T1;
    drive_bit(sel, 1'b0, t);
    for (int i = 0; i < 8; i++) drive_bit(sel, b[i], t);
`ifdef UART_RX_PARITY_EN
    drive_bit(sel, par_b, t);
`else
    if (par_b === 1'bx) $display("[TB] parity bit unknown");
`endif
    drive_bit(sel, stop_b, t);
  endtask

  task automatic pop_check(input int sel, input string tag, input logic [7:0] exp);
    @(negedge clk);
    if (sel == 0) u0_if.uart_fifo_read_en = 1'b1; else u1_if.uart_fifo_read_en = 1'b1;
    @(negedge clk);
    u0_if.uart_fifo_read_en = 1'b0;
    u1_if.uart_fifo_read_en = 1'b0;
    if (sel == 0) begin
      check({tag, "_valid"}, u0_if.fifo_out_valid, 1);
      check({tag, "_data"}, u0_if.uart_fifo_data, exp);
    end else begin
      check({tag, "_valid"}, u1_if.fifo_out_valid, 1);
      check({tag, "_data"}, u1_if.uart_fifo_data, exp);
    end
    @(negedge clk);
    if (sel == 0) check({tag, "_valid_drop"}, u0_if.fifo_out_valid, 0);
    else          check({tag, "_valid_drop"}, u1_if.fifo_out_valid, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_empty"}, u0_if.fifo_empty, 1);
    check({tag, "_valid"}, u0_if.fifo_out_valid, 0);
    check({tag, "_data"}, u0_if.uart_fifo_data, 8'h00);
    check({tag, "_ferr"}, u0_if.frame_error, 0);
    check({tag, "_perr"}, u0_if.parity_error, 0);
    check({tag, "_ovr"}, u0_if.overrun, 0);
    check({tag, "_state"}, u0_if.rx_state, 3'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int fe_before;
    logic [7:0] b;

    u0_if.uart_input_line = 1'b1;
    u0_if.uart_fifo_read_en = 1'b0;
    u1_if.uart_input_line = 1'b1;
    u1_if.uart_fifo_read_en = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst");
    check("rst_empty1", u1_if.fifo_empty, 1);

    // Basic byte at 434 cycles/bit.
    send(0, 8'hA5, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    check("a5_not_empty", u0_if.fifo_empty, 0);
    pop_check(0, "a5_pop", 8'hA5);
    check("a5_empty_after", u0_if.fifo_empty, 1);
    check("a5_ferr_cnt", fe0, 0);
    check("a5_perr_cnt", pe0, 0);

    // Read of an empty FIFO is ignored.
    @(negedge clk);
    u0_if.uart_fifo_read_en = 1'b1;
    @(negedge clk);
    u0_if.uart_fifo_read_en = 1'b0;
    check("empty_read_valid", u0_if.fifo_out_valid, 0);

    // Short low glitch must be rejected at the start-bit midpoint.
    u0_if.uart_input_line = 1'b0;
    repeat (100) @(negedge clk);
    u0_if.uart_input_line = 1'b1;
    repeat (400) @(negedge clk);
    check("glitch_state", u0_if.rx_state, 3'd0);
    check("glitch_empty", u0_if.fifo_empty, 1);
    check("glitch_ferr", fe0, 0);

    // Stop bit low, then line held low.
    send(0, 8'h3C, 1'b0, 1'b0);
    check("ferr_pulse_cnt", fe0, 1);
    check("ferr_state_break", u0_if.rx_state, 3'd5);
    repeat (2000) @(negedge clk);
    check("ferr_held_state", u0_if.rx_state, 3'd5);
    check("ferr_held_cnt", fe0, 1);
    check("ferr_no_push", u0_if.fifo_empty, 1);
    u0_if.uart_input_line = 1'b1;
    repeat (20) @(negedge clk);
    check("ferr_idle_state", u0_if.rx_state, 3'd0);
    check("ferr_still_empty", u0_if.fifo_empty, 1);
    check("ferr_perr_cnt", pe0, 0);

`ifdef UART_RX_PARITY_EN
    send(0, 8'h07, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    check("par_bad_pulse", pe0, 1);
    check("par_bad_no_push", u0_if.fifo_empty, 1);
    send(0, 8'h07, 1'b1, 1'b1);
    repeat (5) @(negedge clk);
    check("par_good_cnt", pe0, 1);
    check("par_good_push", u0_if.fifo_empty, 0);
    pop_check(0, "par_pop", 8'h07);
`endif

    // Reset in the middle of data bit 4 of 8'h5A.
    b = 8'h5A;
    fe_before = fe0;
    drive_bit(0, 1'b0, T0);
    for (int i = 0; i < 4; i++) drive_bit(0, b[i], T0);
    drive_bit(0, b[4], T0 / 2);
    check("mid_state_data", u0_if.rx_state, 3'd2);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    u0_if.uart_input_line = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    repeat (T0) @(negedge clk);
    check("midrst_no_push", u0_if.fifo_empty, 1);
    send(0, 8'h5A, 1'b1, ^b);
    repeat (5) @(negedge clk);
    pop_check(0, "midrst_5a", 8'h5A);
    check("midrst_ferr", fe0, fe_before);

    // Fill a 32-entry FIFO with 33 bytes at 16 cycles/bit.
    for (int i = 0; i < 33; i++) begin
      b = 8'(i);
      send(1, b, 1'b1, ^b);
      if (i < 32) exp_q.push_back(b);
      if (i == 31) check("ovr_before", u1_if.overrun, 0);
    end
    repeat (5) @(negedge clk);
    check("ovr_set", u1_if.overrun, 1);
    check("ovr_ferr", fe1, 0);
    check("ovr_perr", pe1, 0);
    while (exp_q.size() > 0) pop_check(1, "ovr_pop", exp_q.pop_front());
    check("ovr_drained_empty", u1_if.fifo_empty, 1);
    check("ovr_sticky", u1_if.overrun, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
